// File: rtl/dsp_sched_pkg.sv
// Shared types for the DSP command scheduler: FSM states and the queued command record.
package dsp_sched_pkg;

    localparam int OP_W_DEF   = 2;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RETIRE,
        ERROR
    } state_t;

    typedef struct packed {
        logic [OP_W_DEF-1:0]   op;
        logic [ADDR_W_DEF-1:0] ra;
        logic [ADDR_W_DEF-1:0] rb;
        logic [ADDR_W_DEF-1:0] rw;
    } cmd_t;

endpackage

// File: rtl/dsp_cmd_fifo.sv
// Circular command FIFO with a registered occupancy count; full/empty derive from the count only.
module dsp_cmd_fifo
    import dsp_sched_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = cmd_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int                 PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]     FULL_CNT = (PTR_W + 1)'(DEPTH);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage carries no reset; validity is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dsp_cmd_scheduler.sv
// Queues DSP commands and issues them one at a time, holding operands until done or timeout.
module dsp_cmd_scheduler
    import dsp_sched_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int OP_W    = OP_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [OP_W-1:0]        cmd_op,
    input  logic [ADDR_W-1:0]      cmd_ra,
    input  logic [ADDR_W-1:0]      cmd_rb,
    input  logic [ADDR_W-1:0]      cmd_rw,
    output logic                   dsp_start,
    output logic [OP_W-1:0]        dsp_op,
    output logic [ADDR_W-1:0]      mem_ra,
    output logic [ADDR_W-1:0]      mem_rb,
    output logic [ADDR_W-1:0]      mem_rw,
    input  logic                   dsp_done,
    output logic                   cmp_valid,
    output logic [ADDR_W-1:0]      cmp_rw,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   err_timeout,
    input  logic                   err_clr
);

    localparam int               TMR_W    = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] ra;
        logic [ADDR_W-1:0] rb;
        logic [ADDR_W-1:0] rw;
    } sched_cmd_t;

    state_t     state;
    state_t     state_next;
    sched_cmd_t in_cmd;
    sched_cmd_t head_cmd;
    sched_cmd_t exec_cmd;
    logic [TMR_W-1:0] timer;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;
    logic       timer_clr;
    logic       timer_inc;
    logic       err_set;
    logic       err_clear;

    assign in_cmd    = '{op: cmd_op, ra: cmd_ra, rb: cmd_rb, rw: cmd_rw};
    assign cmd_ready = ~fifo_full;
    assign push      = cmd_valid & cmd_ready;

    dsp_cmd_fifo #(
        .DEPTH (DEPTH),
        .T     (sched_cmd_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (in_cmd),
        .pop       (pop),
        .head      (head_cmd),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        dsp_start  = 1'b0;
        cmp_valid  = 1'b0;
        timer_clr  = 1'b0;
        timer_inc  = 1'b0;
        err_set    = 1'b0;
        err_clear  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                dsp_start  = 1'b1;
                timer_clr  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                // Done wins over a timeout landing in the same cycle.
                if (dsp_done) begin
                    state_next = RETIRE;
                end else if (timer == TMR_LAST) begin
                    err_set    = 1'b1;
                    state_next = ERROR;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            RETIRE: begin
                cmp_valid  = 1'b1;
                state_next = IDLE;
            end
            ERROR: begin
                if (err_clr) begin
                    err_clear  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands latch only on the pop, so they stay stable from ISSUE through RETIRE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exec_cmd <= '0;
        end else if (pop) begin
            exec_cmd <= head_cmd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer       <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (timer_clr) begin
                timer <= '0;
            end else if (timer_inc) begin
                timer <= timer + 1'b1;
            end
            if (err_set) begin
                err_timeout <= 1'b1;
            end else if (err_clear) begin
                err_timeout <= 1'b0;
            end
        end
    end

    assign dsp_op = exec_cmd.op;
    assign mem_ra = exec_cmd.ra;
    assign mem_rb = exec_cmd.rb;
    assign mem_rw = exec_cmd.rw;
    assign cmp_rw = exec_cmd.rw;
    assign busy   = ~fifo_empty | (state != IDLE);

endmodule

// File: doc/dsp_cmd_scheduler.md
# dsp_cmd_scheduler

Command scheduler between the CPU pipeline's DSP issue port and the vector DSP / DSP memory pair. It buffers DSP commands (operation plus three vector-register addresses) in a small FIFO and issues them one at a time. For each command it drives a single-cycle start pulse and holds stable operands until the DSP reports completion. It also supervises each operation with a timeout, so the CPU is never stalled forever by a hung DSP.

## Interface
Parameters:
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- OP_W, 2, DSP operation code width
- ADDR_W, 5, vector-register address width
- TIMEOUT, 64, maximum cycles in WAIT before a timeout error (≥2)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- cmd_valid  in  1  CPU presents a command
- cmd_ready  out  1  FIFO can accept; transfer when cmd_valid & cmd_ready
- cmd_op  in  OP_W  operation
- cmd_ra / cmd_rb / cmd_rw  in  ADDR_W each  source A, source B, destination
- dsp_start  out  1  one-cycle start pulse to DSP
- dsp_op  out  OP_W  operation to DSP, held during execution
- mem_ra / mem_rb / mem_rw  out  ADDR_W each  addresses to DSP memory, held during execution
- dsp_done  in  1  DSP completion pulse
- cmp_valid  out  1  one-cycle pulse: a command retired
- cmp_rw  out  ADDR_W  destination of the retired command, valid with cmp_valid
- busy  out  1  FIFO non-empty or FSM not IDLE
- fifo_count  out  $clog2(DEPTH)+1  entries currently queued
- err_timeout  out  1  sticky timeout flag
- err_clr  in  1  clears err_timeout, leaves ERROR

## Operation
- FIFO: circular, registered count. cmd_ready = (count < DEPTH); it is computed from the registered count only, so a pop in the same cycle does not allow a push when full. A simultaneous push and pop keeps count unchanged. Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if FIFO non-empty, pop head into the execution registers and go to ISSUE.
  - ISSUE: dsp_start=1 for exactly this cycle; clear the timer; go to WAIT.
  - WAIT: on dsp_done go to RETIRE. When the timer reaches TIMEOUT-1 without dsp_done, set err_timeout and go to ERROR. Otherwise increment the timer.
  - RETIRE: cmp_valid=1 with cmp_rw = held destination; go to IDLE.
  - ERROR: issues no commands; FIFO keeps accepting while not full. On err_clr, clear err_timeout, discard the hung command (no cmp_valid), and go to IDLE.
- dsp_op/mem_ra/mem_rb/mem_rw change only on the IDLE→ISSUE transition and are stable from ISSUE through RETIRE.
- dsp_done is ignored outside WAIT. dsp_done arriving together with the timer's last WAIT cycle counts as done, not as a timeout.
- err_clr outside ERROR is ignored.
- Commands execute strictly in acceptance order.

## Timing
- Reset values: cmd_ready=1, dsp_start=0, dsp_op=0, mem_ra/mem_rb/mem_rw=0, cmp_valid=0, cmp_rw=0, busy=0, fifo_count=0, err_timeout=0, FSM=IDLE, FIFO empty.
- Command accepted at edge N (into an empty FIFO, FSM IDLE): IDLE pops at N+1, dsp_start is high in cycle N+2.
- dsp_done sampled at edge M in WAIT: cmp_valid is high in the cycle after M; the next dsp_start comes at least 2 cycles after cmp_valid.
- Minimum issue period: 4 cycles per command when the DSP asserts done in the first WAIT cycle.
- Reset asserted mid-operation: everything returns to reset values immediately, queued commands are lost, and a dsp_done arriving afterwards is ignored.

## Structure
- Shared package dsp_sched_pkg: FSM state enum (IDLE, ISSUE, WAIT, RETIRE, ERROR), packed command struct {op, ra, rb, rw}, default OP_W/ADDR_W constants.
- Sub-module dsp_cmd_fifo: parameterised synchronous FIFO storing the command struct, with push/pop/count/full/empty. The FSM and timer stay in the top module.

## Test plan
- Single command: op=2, ra=1, rb=2, rw=3 accepted at cycle 0; dsp_start pulses at cycle 2 with mem_rw=3; dsp_done at cycle 5 → cmp_valid at cycle 6 with cmp_rw=3; busy drops at cycle 7.
- Back-pressure: push 5 commands back-to-back while DSP done is withheld → cmd_ready=0 when fifo_count=4; 5th command accepted only after the first pop; all retire in order with rw=0..4.
- Timeout: no dsp_done for 64 WAIT cycles → err_timeout=1, state ERROR, no further dsp_start; pulse err_clr → flag clears, next queued command issues with no cmp_valid for the dropped one.
- Done/timeout race: dsp_done on the 64th WAIT cycle → cmp_valid, err_timeout stays 0.
- Spurious done: dsp_done pulsed in IDLE and ISSUE → no state change, no cmp_valid.
- Reset mid-WAIT with 3 queued commands → all outputs at reset values next cycle, fifo_count=0, later dsp_done ignored.
